load_store_unit: RTL and testbench

Sits between the execute stage and the byte-banked data memory and sequences each load or store as one transaction. It accepts a request from execute over a valid/ready handshake and checks it for size, range and alignment faults. It then drives the memory's address/write-mask/read-mask port for exactly one cycle, captures the one-cycle-latency read data, and returns a registered response over a second valid/ready handshake. Only one transaction is in flight at a time.

---
 rtl/load_store_unit.sv | 180 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// ============================================================================
// load_store_unit : sequences one load/store at a time into byte-banked memory
// Revision: 1.0
// ============================================================================
`default_nettype none

module load_store_unit #(
  parameter int unsigned ADDR_LIMIT = 4096
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic [1:0]  o_resp_err_code,
  output logic [31:0] o_mem_address,
  output logic [31:0] o_mem_wr_data,
  output logic [1:0]  o_mem_wr_mask,
  output logic [2:0]  o_mem_rd_mask,
  input  logic [31:0] i_mem_rd_data,
  input  logic        i_mem_err_misaligned,
  input  logic        i_mem_err_rdmask
);

  localparam logic [1:0] c_WR_N  = 2'd0;
  localparam logic [1:0] c_WR_B  = 2'd1;
  localparam logic [1:0] c_WR_H  = 2'd2;
  localparam logic [1:0] c_WR_W  = 2'd3;
  localparam logic [2:0] c_RD_W  = 3'd0;
  localparam logic [2:0] c_RD_HZ = 3'd1;
  localparam logic [2:0] c_RD_BZ = 3'd2;
  localparam logic [2:0] c_RD_HE = 3'd3;
  localparam logic [2:0] c_RD_BE = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEM  = 2'd1,
    S_CAP  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_we;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_mem_address;
  logic [31:0] r_mem_wr_data;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;
  logic [1:0]  r_resp_err_code;

  logic        w_accept;
  logic        w_misaligned;
  logic [1:0]  w_fault_code;
  logic        w_mem_err;

  assign w_accept     = i_req_valid && (r_state == S_IDLE);
  assign w_misaligned = ((i_req_size == 2'd2) && (i_req_addr[1:0] != 2'b00)) ||
                        ((i_req_size == 2'd1) && i_req_addr[0]);
  assign w_mem_err    = i_mem_err_misaligned | i_mem_err_rdmask;

  // Priority: illegal size, then range, then alignment.
  always_comb begin
    w_fault_code = 2'd0;
    if (i_req_size == 2'd3)            w_fault_code = 2'd3;
    else if (i_req_addr >= ADDR_LIMIT) w_fault_code = 2'd2;
    else if (w_misaligned)             w_fault_code = 2'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    o_req_ready   = 1'b0;
    o_resp_valid  = 1'b0;
    o_mem_wr_mask = c_WR_N;
    o_mem_rd_mask = c_RD_W;
    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) w_next = (w_fault_code != 2'd0) ? S_RESP : S_MEM;
      end
      S_MEM: begin
        w_next = S_CAP;
        if (r_we) begin
          case (r_size)
            2'd0:    o_mem_wr_mask = c_WR_B;
            2'd1:    o_mem_wr_mask = c_WR_H;
            default: o_mem_wr_mask = c_WR_W;
          endcase
        end else begin
          case (r_size)
            2'd0:    o_mem_rd_mask = r_unsigned ? c_RD_BZ : c_RD_BE;
            2'd1:    o_mem_rd_mask = r_unsigned ? c_RD_HZ : c_RD_HE;
            default: o_mem_rd_mask = c_RD_W;
          endcase
        end
      end
      S_CAP:  w_next = S_RESP;
      S_RESP: begin
        o_resp_valid = 1'b1;
        if (i_resp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Reset landing in MEM must never let a write through.
    if (i_reset) o_mem_wr_mask = c_WR_N;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_we            <= 1'b0;
      r_size          <= 2'd0;
      r_unsigned      <= 1'b0;
      r_mem_address   <= 32'd0;
      r_mem_wr_data   <= 32'd0;
      r_resp_rdata    <= 32'd0;
      r_resp_err      <= 1'b0;
      r_resp_err_code <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we       <= i_req_we;
            r_size     <= i_req_size;
            r_unsigned <= i_req_unsigned;
            if (w_fault_code != 2'd0) begin
              r_resp_rdata    <= 32'd0;
              r_resp_err      <= 1'b1;
              r_resp_err_code <= w_fault_code;
            end else begin
              r_mem_address <= i_req_addr;
              r_mem_wr_data <= i_req_wdata;
            end
          end
        end
        S_CAP: begin
          if (w_mem_err) begin
            r_resp_rdata    <= 32'd0;
            r_resp_err      <= 1'b1;
            r_resp_err_code <= 2'd3;
          end else begin
            r_resp_rdata    <= r_we ? 32'd0 : i_mem_rd_data;
            r_resp_err      <= 1'b0;
            r_resp_err_code <= 2'd0;
          end
        end
        S_RESP: begin
          if (i_resp_ready) begin
            r_resp_err      <= 1'b0;
            r_resp_err_code <= 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_mem_address   = r_mem_address;
  assign o_mem_wr_data   = r_mem_wr_data;
  assign o_resp_rdata    = r_resp_rdata;
  assign o_resp_err      = r_resp_err;
  assign o_resp_err_code = r_resp_err_code;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// tb_load_store_unit : randomized self-checking bench with byte-level reference
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_load_store_unit;

  localparam int unsigned ADDR_LIMIT = 4096;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        i_req_we;
  logic [1:0]  i_req_size;
  logic        i_req_unsigned;
  logic        o_resp_valid;
  logic        i_resp_ready;
  logic [31:0] o_resp_rdata;
  logic        o_resp_err;
  logic [1:0]  o_resp_err_code;
  logic [31:0] o_mem_address;
  logic [31:0] o_mem_wr_data;
  logic [1:0]  o_mem_wr_mask;
  logic [2:0]  o_mem_rd_mask;
  logic [31:0] i_mem_rd_data;
  logic        i_mem_err_misaligned;
  logic        i_mem_err_rdmask;

  int n_total = 0;
  int n_bad   = 0;

  always #5 i_clk = ~i_clk;

  load_store_unit #(.ADDR_LIMIT(ADDR_LIMIT)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_we(i_req_we),
    .i_req_size(i_req_size), .i_req_unsigned(i_req_unsigned),
    .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
    .o_resp_rdata(o_resp_rdata), .o_resp_err(o_resp_err),
    .o_resp_err_code(o_resp_err_code),
    .o_mem_address(o_mem_address), .o_mem_wr_data(o_mem_wr_data),
    .o_mem_wr_mask(o_mem_wr_mask), .o_mem_rd_mask(o_mem_rd_mask),
    .i_mem_rd_data(i_mem_rd_data),
    .i_mem_err_misaligned(i_mem_err_misaligned), .i_mem_err_rdmask(i_mem_err_rdmask)
  );

  // Byte-banked memory: one-cycle read latency, extension done here.
  logic [7:0]  mem [0:4095];
  logic        fill_mem;
  logic        inj_err;
  logic        inj_sel;
  logic [11:0] ma;
  logic [31:0] m_word;
  logic [15:0] m_half;
  logic [7:0]  m_byte;

  assign ma     = o_mem_address[11:0];
  assign m_word = {mem[{ma[11:2], 2'd3}], mem[{ma[11:2], 2'd2}],
                   mem[{ma[11:2], 2'd1}], mem[{ma[11:2], 2'd0}]};
  assign m_half = {mem[{ma[11:1], 1'b1}], mem[{ma[11:1], 1'b0}]};
  assign m_byte = mem[ma];
  assign i_mem_err_misaligned = inj_err & inj_sel;
  assign i_mem_err_rdmask     = inj_err & ~inj_sel;

  always @(posedge i_clk) begin
    if (fill_mem) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'(i * 37 + 5);
    end else begin
      case (o_mem_wr_mask)
        2'd1: mem[ma] <= o_mem_wr_data[7:0];
        2'd2: begin
          mem[{ma[11:1], 1'b0}] <= o_mem_wr_data[7:0];
          mem[{ma[11:1], 1'b1}] <= o_mem_wr_data[15:8];
        end
        2'd3: begin
          mem[{ma[11:2], 2'd0}] <= o_mem_wr_data[7:0];
          mem[{ma[11:2], 2'd1}] <= o_mem_wr_data[15:8];
          mem[{ma[11:2], 2'd2}] <= o_mem_wr_data[23:16];
          mem[{ma[11:2], 2'd3}] <= o_mem_wr_data[31:24];
        end
        default: ;
      endcase
    end
    case (o_mem_rd_mask)
      3'd0:    i_mem_rd_data <= m_word;
      3'd1:    i_mem_rd_data <= {16'd0, m_half};
      3'd2:    i_mem_rd_data <= {24'd0, m_byte};
      3'd3:    i_mem_rd_data <= {{16{m_half[15]}}, m_half};
      3'd4:    i_mem_rd_data <= {{24{m_byte[7]}}, m_byte};
      default: i_mem_rd_data <= 32'd0;
    endcase
  end

  // Reference model: flat byte array, little-endian.
  logic [7:0] ref_mem [0:4095];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [1:0] ref_code(input logic [31:0] addr, input logic [1:0] size);
    if (size == 2'd3) return 2'd3;
    if (addr >= ADDR_LIMIT) return 2'd2;
    if ((addr % nbytes(size)) != 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size,
                                           input logic uns);
    longint v = 0;
    int     n = nbytes(size);
    for (int i = 0; i < n; i++) v += longint'(ref_mem[addr + i]) << (8 * i);
    if (!uns && n < 4 && v[8 * n - 1]) v -= (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_req_ready"}, {31'd0, o_req_ready}, 32'd1);
    check({tag, "_resp_valid"}, {31'd0, o_resp_valid}, 32'd0);
    check({tag, "_rdata"}, o_resp_rdata, 32'd0);
    check({tag, "_err"}, {29'd0, o_resp_err, o_resp_err_code}, 32'd0);
    check({tag, "_masks"}, {27'd0, o_mem_wr_mask, o_mem_rd_mask}, 32'd0);
    check({tag, "_maddr"}, o_mem_address, 32'd0);
    check({tag, "_mwdata"}, o_mem_wr_data, 32'd0);
  endtask

  // Called #1 after a rising edge; returns #1 after a rising edge.
  task automatic txn(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                     input logic [1:0] size, input logic uns, input int delay,
                     input logic inj, input logic hold_req);
    logic [1:0]  code   = ref_code(addr, size);
    logic [31:0] exp_rd = 32'd0;
    logic [1:0]  exp_wm = 2'd0;
    logic [2:0]  exp_rm = 3'd0;
    int          n      = 0;
    if (code == 2'd0) begin
      if (!we) exp_rd = ref_load(addr, size, uns);
      if (we)  exp_wm = 2'(size + 2'd1);
      else if (size == 2'd1) exp_rm = uns ? 3'd1 : 3'd3;
      else if (size == 2'd0) exp_rm = uns ? 3'd2 : 3'd4;
      if (inj) begin code = 2'd3; exp_rd = 32'd0; end
    end
    check("idle_ready", {31'd0, o_req_ready}, 32'd1);
    i_req_addr = addr; i_req_wdata = wdata; i_req_we = we;
    i_req_size = size; i_req_unsigned = uns; i_req_valid = 1'b1;
    inj_err = inj; inj_sel = 1'($urandom);
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    while (!o_resp_valid && n < 8) begin
      if (n == 0) begin
        check("mem_addr", o_mem_address, addr);
        check("mem_wdata", o_mem_wr_data, wdata);
        check("mem_wr_mask", {30'd0, o_mem_wr_mask}, {30'd0, exp_wm});
        check("mem_rd_mask", {29'd0, o_mem_rd_mask}, {29'd0, exp_rm});
      end else begin
        check("cap_wr_mask", {30'd0, o_mem_wr_mask}, 32'd0);
      end
      @(posedge i_clk); #1;
      n++;
    end
    check("latency", 32'(n), (ref_code(addr, size) != 2'd0) ? 32'd0 : 32'd2);
    for (int d = 0; d < delay; d++) begin
      if (hold_req) begin
        i_req_valid = 1'b1; i_req_addr = $urandom_range(0, 255); i_req_we = 1'b1;
        i_req_size = 2'd0; i_req_wdata = $urandom;
      end
      check("hold_valid", {31'd0, o_resp_valid}, 32'd1);
      check("hold_ready", {31'd0, o_req_ready}, 32'd0);
      check("hold_rdata", o_resp_rdata, exp_rd);
      check("hold_code", {29'd0, o_resp_err, o_resp_err_code}, {29'd0, code != 2'd0, code});
      check("hold_wr_mask", {30'd0, o_mem_wr_mask}, 32'd0);
      @(posedge i_clk); #1;
    end
    i_resp_ready = 1'b1;
    check("resp_valid", {31'd0, o_resp_valid}, 32'd1);
    check("resp_rdata", o_resp_rdata, exp_rd);
    check("resp_err", {29'd0, o_resp_err, o_resp_err_code}, {29'd0, code != 2'd0, code});
    @(posedge i_clk); #1;
    i_resp_ready = 1'b0; i_req_valid = 1'b0; inj_err = 1'b0;
    check("post_valid", {31'd0, o_resp_valid}, 32'd0);
    check("post_ready", {31'd0, o_req_ready}, 32'd1);
    check("post_err", {29'd0, o_resp_err, o_resp_err_code}, 32'd0);
    if (we && ref_code(addr, size) == 2'd0)
      for (int i = 0; i < nbytes(size); i++) ref_mem[addr + i] = 8'(wdata >> (8 * i));
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'(i * 37 + 5);
    i_reset = 1'b1; fill_mem = 1'b1; inj_err = 1'b0; inj_sel = 1'b0;
    i_req_valid = 1'b0; i_req_addr = 32'd0; i_req_wdata = 32'd0; i_req_we = 1'b0;
    i_req_size = 2'd0; i_req_unsigned = 1'b0; i_resp_ready = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check_reset_state("rst");
    i_reset = 1'b0; fill_mem = 1'b0;

    txn(32'h40, 32'hDEADBEEF, 1'b1, 2'd2, 1'b0, 0, 1'b0, 1'b0);
    txn(32'h40, 32'h0, 1'b0, 2'd2, 1'b0, 0, 1'b0, 1'b0);
    check("plan_word", ref_load(32'h40, 2'd2, 1'b0), 32'hDEADBEEF);
    txn(32'h43, 32'h0, 1'b0, 2'd0, 1'b0, 0, 1'b0, 1'b0);
    txn(32'h43, 32'h0, 1'b0, 2'd0, 1'b1, 0, 1'b0, 1'b0);
    txn(32'h40, 32'h0, 1'b0, 2'd1, 1'b0, 0, 1'b0, 1'b0);
    txn(32'h41, 32'h12, 1'b1, 2'd0, 1'b0, 0, 1'b0, 1'b0);
    txn(32'h40, 32'h0, 1'b0, 2'd2, 1'b0, 0, 1'b0, 1'b0);
    check("plan_byte_merge", ref_load(32'h40, 2'd2, 1'b0), 32'hDEAD12EF);
    txn(32'h42, 32'h0, 1'b0, 2'd2, 1'b0, 0, 1'b0, 1'b0);
    txn(32'h1000, 32'h0, 1'b0, 2'd2, 1'b0, 0, 1'b0, 1'b0);
    txn(32'h1001, 32'h0, 1'b0, 2'd3, 1'b0, 0, 1'b0, 1'b0);
    txn(32'h40, 32'h0, 1'b0, 2'd2, 1'b0, 5, 1'b0, 1'b1);

    // Reset landing in the MEM cycle of a store.
    i_req_addr = 32'h80; i_req_wdata = 32'h55AA55AA; i_req_we = 1'b1;
    i_req_size = 2'd2; i_req_valid = 1'b1;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    check("rstmem_wr_mask_pre", {30'd0, o_mem_wr_mask}, 32'd3);
    i_reset = 1'b1;
    #1;
    check("rstmem_wr_mask_forced", {30'd0, o_mem_wr_mask}, 32'd0);
    @(posedge i_clk); #1;
    check_reset_state("rstmem");
    i_reset = 1'b0;
    @(posedge i_clk); #1;
    txn(32'h80, 32'h0, 1'b0, 2'd2, 1'b0, 0, 1'b0, 1'b0);

    for (int t = 0; t < 300; t++) begin
      logic [31:0] a;
      int          r = $urandom_range(0, 9);
      if (r == 0)      a = 32'h1000 + $urandom_range(0, 15);
      else if (r == 1) a = $urandom;
      else             a = $urandom_range(0, 255);
      txn(a, $urandom, 1'($urandom), ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
          1'($urandom), $urandom_range(0, 3), ($urandom_range(0, 7) == 0), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
